// File: rtl/mai_wr_arbiter_if.sv
// Write-channel bundle: request handshake plus write-beat handshake.
// The requester side uses master; the arbiter's requester-facing ports use slave.
interface mai_wr_arbiter_if #(
   parameter int unsigned RW = 45,
   parameter int unsigned WW = 37
);
   logic          Valid;
   logic [RW-1:0] Req;
   logic          Ready;
   logic          WValid;
   logic [WW-1:0] W;
   logic          WReady;

   modport master (output Valid, Req, WValid, W, input Ready, WReady);
   modport slave  (input Valid, Req, WValid, W, output Ready, WReady);
endinterface

// File: rtl/mai_wr_arbiter.sv
// QoS + age write arbiter sharing one MAC write port between IF and DM.
// The grant is held from the address phase through the last data beat.
module mai_wr_arbiter (
   input  logic             clk,
   input  logic             resetn,
   mai_wr_arbiter_if.slave  i_if,
   mai_wr_arbiter_if.slave  i_dm,
   mai_wr_arbiter_if.master o_mac,
   output logic [1:0]       oGrant,
   output logic             oProtoErr
);
   localparam int unsigned RW    = 45;
   localparam int unsigned WW    = 37;
   localparam int unsigned AGE_W = 4;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned P_W   = 5;
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(15);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t            r_state, w_state_nxt;
   logic [RW-1:0]     r_req;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_grant;
   logic              r_last_dm;
   logic [AGE_W-1:0]  r_age_if, r_age_dm;
   logic              r_proto_err;

   logic [P_W-1:0]    w_p_if, w_p_dm;
   logic              w_if_aged, w_dm_aged, w_pick_dm;
   logic              w_if_ready, w_dm_ready, w_hs_req;
   logic [RW-1:0]     w_sel_req;
   logic              w_src_wvalid, w_src_eod, w_cnt_one;
   logic [WW-1:0]     w_src_w, w_mac_w;
   logic              w_if_wready, w_dm_wready;
   logic              w_beat_hs, w_last;

   assign w_p_if    = P_W'(i_if.Req[3:0]) + P_W'(r_age_if);
   assign w_p_dm    = P_W'(i_dm.Req[3:0]) + P_W'(r_age_dm);
   assign w_if_aged = (r_age_if == AGE_MAX);
   assign w_dm_aged = (r_age_dm == AGE_MAX);
   assign w_cnt_one = (r_cnt == CNT_W'(1));

   // Winner selection: a saturated age wins outright, then higher P, then the requester not granted last
   always_comb begin
      w_pick_dm = 1'b0;
      if (i_if.Valid && i_dm.Valid) begin
         if (w_if_aged != w_dm_aged)
            w_pick_dm = w_dm_aged;
         else if (!w_if_aged && (w_p_if != w_p_dm))
            w_pick_dm = (w_p_dm > w_p_if);
         else
            w_pick_dm = !r_last_dm;
      end else begin
         w_pick_dm = i_dm.Valid;
      end
   end

   assign w_sel_req = w_pick_dm ? i_dm.Req : i_if.Req;

   // Next state and the combinational handshake/pass-through paths
   always_comb begin
      w_state_nxt  = r_state;
      w_if_ready   = 1'b0;
      w_dm_ready   = 1'b0;
      w_src_wvalid = 1'b0;
      w_src_w      = '0;
      w_src_eod    = 1'b0;
      w_mac_w      = '0;
      w_if_wready  = 1'b0;
      w_dm_wready  = 1'b0;
      w_beat_hs    = 1'b0;
      w_last       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            // Held low while resetn is asserted so every output is 0 in reset
            w_if_ready = resetn & i_if.Valid & ~w_pick_dm;
            w_dm_ready = resetn & i_dm.Valid &  w_pick_dm;
            if (w_if_ready || w_dm_ready)
               w_state_nxt = S_ADDR;
         end
         S_ADDR: begin
            if (o_mac.Ready)
               w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_src_wvalid = r_grant[1] ? i_dm.WValid : i_if.WValid;
            w_src_w      = r_grant[1] ? i_dm.W      : i_if.W;
            w_src_eod    = w_src_w[WW-1];
            w_mac_w      = {w_src_eod | w_cnt_one, w_src_w[WW-2:0]};
            w_if_wready  = r_grant[0] & o_mac.WReady;
            w_dm_wready  = r_grant[1] & o_mac.WReady;
            w_beat_hs    = w_src_wvalid & o_mac.WReady;
            w_last       = w_src_eod | w_cnt_one;
            if (w_beat_hs && w_last)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_hs_req = w_if_ready | w_dm_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_req       <= '0;
         r_cnt       <= '0;
         r_grant     <= 2'b00;
         r_last_dm   <= 1'b1;
         r_age_if    <= '0;
         r_age_dm    <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_proto_err <= w_beat_hs & w_last & (w_src_eod != w_cnt_one);
         if (w_hs_req) begin
            r_req     <= w_sel_req;
            r_cnt     <= CNT_W'(w_sel_req[5:4]) + CNT_W'(1);
            r_grant   <= w_pick_dm ? 2'b10 : 2'b01;
            r_last_dm <= w_pick_dm;
            if (w_pick_dm) begin
               r_age_dm <= '0;
               if (i_if.Valid && !w_if_aged)
                  r_age_if <= r_age_if + AGE_W'(1);
            end else begin
               r_age_if <= '0;
               if (i_dm.Valid && !w_dm_aged)
                  r_age_dm <= r_age_dm + AGE_W'(1);
            end
         end
         if (w_beat_hs) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last)
               r_grant <= 2'b00;
         end
      end
   end

   assign i_if.Ready   = w_if_ready;
   assign i_dm.Ready   = w_dm_ready;
   assign i_if.WReady  = w_if_wready;
   assign i_dm.WReady  = w_dm_wready;
   assign o_mac.Valid  = (r_state == S_ADDR);
   assign o_mac.Req    = r_req;
   assign o_mac.WValid = w_src_wvalid;
   assign o_mac.W      = w_mac_w;
   assign oGrant       = r_grant;
   assign oProtoErr    = r_proto_err;
endmodule

// File: tb/tb_mai_wr_arbiter.sv
// Scoreboard bench for mai_wr_arbiter: directed bursts push expected MAC traffic,
// a negedge monitor pops and compares every MAC handshake and the error pulse.
module tb_mai_wr_arbiter;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic [1:0] grant;
   logic perr;

   mai_wr_arbiter_if if_ch ();
   mai_wr_arbiter_if dm_ch ();
   mai_wr_arbiter_if mac_ch ();

   mai_wr_arbiter dut (
      .clk       (clk),
      .resetn    (resetn),
      .i_if      (if_ch),
      .i_dm      (dm_ch),
      .o_mac     (mac_ch),
      .oGrant    (grant),
      .oProtoErr (perr)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   logic [46:0] req_q[$];   // {grant, req}
   logic [39:0] beat_q[$];  // {proto_err, grant, W}
   logic err_due = 1'b0;

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic void fail_now(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event missing or unexpected", nm);
   endfunction

   function automatic logic [44:0] mk_req(input bit dm, input logic [7:0] tag,
                                          input logic [1:0] len, input logic [3:0] qos);
      logic [31:0] a = 32'h8000_0000 | {16'h0, tag, 8'h0};
      logic [2:0] id = dm ? 3'd2 : 3'd1;
      return {a, tag[3:0], id, len, qos};
   endfunction

   function automatic logic [36:0] src_beat(input logic [7:0] tag, input int b, input int eodbeat);
      logic eod = (b == eodbeat);
      return {eod, 4'hF, 16'hD000, tag, 8'(b)};
   endfunction

   // Expected MAC traffic for one burst, in the order the test predicts it is granted
   function automatic void exp_burst(input bit dm, input logic [3:0] qos, input logic [1:0] len,
                                     input int nbeats, input int eodbeat, input logic [7:0] tag);
      logic [1:0] g = dm ? 2'b10 : 2'b01;
      logic [36:0] s;
      logic eod_x, err_x;
      req_q.push_back({g, mk_req(dm, tag, len, qos)});
      for (int b = 1; b <= nbeats; b++) begin
         s     = src_beat(tag, b, eodbeat);
         eod_x = s[36] | (b == int'(len) + 1);
         err_x = (b == nbeats) && (s[36] != (b == int'(len) + 1));
         beat_q.push_back({err_x, g, eod_x, s[35:0]});
      end
   endfunction

   task automatic wait_sig(input int sel, input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         case (sel)
            0: seen = if_ch.Ready;
            1: seen = dm_ch.Ready;
            2: seen = if_ch.WReady;
            default: seen = dm_ch.WReady;
         endcase
      end
      if (!seen) fail_now(nm);
   endtask

   // Requester driver; called just after a posedge, returns just after a posedge
   task automatic req_burst(input bit dm, input logic [3:0] qos, input logic [1:0] len,
                            input int nbeats, input int eodbeat, input logic [7:0] tag);
      if (dm) begin dm_ch.Valid = 1'b1; dm_ch.Req = mk_req(dm, tag, len, qos); end
      else    begin if_ch.Valid = 1'b1; if_ch.Req = mk_req(dm, tag, len, qos); end
      wait_sig(dm ? 1 : 0, "req_ready_timeout");
      @(posedge clk); #1;
      if (dm) dm_ch.Valid = 1'b0; else if_ch.Valid = 1'b0;
      for (int b = 1; b <= nbeats; b++) begin
         if (dm) begin dm_ch.WValid = 1'b1; dm_ch.W = src_beat(tag, b, eodbeat); end
         else    begin if_ch.WValid = 1'b1; if_ch.W = src_beat(tag, b, eodbeat); end
         wait_sig(dm ? 3 : 2, "beat_ready_timeout");
         @(posedge clk); #1;
      end
      if (dm) dm_ch.WValid = 1'b0; else if_ch.WValid = 1'b0;
   endtask

   // Monitor: pops expectations on MAC handshakes and checks the error pulse every cycle
   always @(negedge clk) begin
      logic [46:0] er;
      logic [39:0] eb;
      check("proto_err", 64'(perr), 64'(err_due));
      err_due = 1'b0;
      if (mac_ch.Valid && mac_ch.Ready) begin
         if (req_q.size() == 0) fail_now("sb_req_unexpected");
         else begin
            er = req_q.pop_front();
            check("sb_mac_req", 64'(mac_ch.Req), 64'(er[44:0]));
            check("sb_req_grant", 64'(grant), 64'(er[46:45]));
         end
      end
      if (mac_ch.WValid && mac_ch.WReady) begin
         if (beat_q.size() == 0) fail_now("sb_beat_unexpected");
         else begin
            eb = beat_q.pop_front();
            check("sb_mac_w", 64'(mac_ch.W), 64'(eb[36:0]));
            check("sb_beat_grant", 64'(grant), 64'(eb[38:37]));
            err_due = eb[39];
         end
      end
   end

   task automatic apply_reset();
      @(posedge clk); #1;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   initial begin
      if_ch.Valid = 0; if_ch.Req = '0; if_ch.WValid = 0; if_ch.W = '0;
      dm_ch.Valid = 0; dm_ch.Req = '0; dm_ch.WValid = 0; dm_ch.W = '0;
      mac_ch.Ready = 1; mac_ch.WReady = 1;

      // Reset state, with a request already pending on IF
      if_ch.Valid = 1; if_ch.Req = mk_req(0, 8'h01, 2'd0, 4'd1);
      #12;
      check("rst_if_ready", 64'(if_ch.Ready), 0);
      check("rst_mac_valid", 64'(mac_ch.Valid), 0);
      check("rst_mac_wvalid", 64'(mac_ch.WValid), 0);
      check("rst_grant", 64'(grant), 0);
      check("rst_mac_req", 64'(mac_ch.Req), 0);
      if_ch.Valid = 0;
      @(posedge clk); #1 resetn = 1'b1;
      repeat (2) @(posedge clk); #1;

      // Single IF burst: QoS 3, Len 2, three beats with EoD on the third
      exp_burst(0, 4'd3, 2'd2, 3, 3, 8'h10);
      fork
         req_burst(0, 4'd3, 2'd2, 3, 3, 8'h10);
         begin
            @(negedge clk);
            check("t1_if_ready_c0", 64'(if_ch.Ready), 1);
            check("t1_mac_valid_c0", 64'(mac_ch.Valid), 0);
            @(negedge clk);
            check("t1_mac_valid_c1", 64'(mac_ch.Valid), 1);
            check("t1_grant_c1", 64'(grant), 64'(2'b01));
            repeat (3) @(negedge clk);
            check("t1_grant_c4", 64'(grant), 64'(2'b01));
            @(negedge clk);
            check("t1_grant_c5", 64'(grant), 0);
         end
      join
      repeat (2) @(posedge clk); #1;

      // QoS contention: DM (9) first, then IF (2)
      exp_burst(1, 4'd9, 2'd1, 2, 2, 8'h20);
      exp_burst(0, 4'd2, 2'd1, 2, 2, 8'h21);
      fork
         req_burst(0, 4'd2, 2'd1, 2, 2, 8'h21);
         req_burst(1, 4'd9, 2'd1, 2, 2, 8'h20);
      join
      repeat (2) @(posedge clk); #1;

      // Starvation: IF loses 15 times to DM QoS 15, wins the 16th arbitration
      for (int i = 0; i < 15; i++) exp_burst(1, 4'd15, 2'd0, 1, 1, 8'(8'h30 + i));
      exp_burst(0, 4'd0, 2'd0, 1, 1, 8'h40);
      exp_burst(1, 4'd15, 2'd0, 1, 1, 8'h3F);
      fork
         for (int i = 0; i < 16; i++) req_burst(1, 4'd15, 2'd0, 1, 1, 8'(8'h30 + i));
         req_burst(0, 4'd0, 2'd0, 1, 1, 8'h40);
      join
      repeat (2) @(posedge clk); #1;

      // Tie round-robin after reset: IF, DM, IF, DM
      apply_reset();
      exp_burst(0, 4'd5, 2'd1, 2, 2, 8'h50);
      exp_burst(1, 4'd5, 2'd1, 2, 2, 8'h51);
      exp_burst(0, 4'd5, 2'd1, 2, 2, 8'h52);
      exp_burst(1, 4'd5, 2'd1, 2, 2, 8'h53);
      fork
         begin req_burst(0, 4'd5, 2'd1, 2, 2, 8'h50); req_burst(0, 4'd5, 2'd1, 2, 2, 8'h52); end
         begin req_burst(1, 4'd5, 2'd1, 2, 2, 8'h51); req_burst(1, 4'd5, 2'd1, 2, 2, 8'h53); end
      join
      repeat (2) @(posedge clk); #1;

      // Protocol errors: early EoD on Len 3, then missing EoD on Len 0
      exp_burst(0, 4'd4, 2'd3, 2, 2, 8'h60);
      exp_burst(1, 4'd4, 2'd0, 1, 0, 8'h61);
      req_burst(0, 4'd4, 2'd3, 2, 2, 8'h60);
      req_burst(1, 4'd4, 2'd0, 1, 0, 8'h61);
      repeat (2) @(posedge clk); #1;

      // Backpressure on beat 2, then asynchronous reset while beat 3 waits
      exp_burst(0, 4'd1, 2'd3, 2, 4, 8'h70);
      if_ch.Valid = 1; if_ch.Req = mk_req(0, 8'h70, 2'd3, 4'd1);
      wait_sig(0, "t6_req_timeout");
      @(posedge clk); #1;
      if_ch.Valid = 0;
      if_ch.WValid = 1; if_ch.W = src_beat(8'h70, 1, 4);
      wait_sig(2, "t6_beat1_timeout");
      @(posedge clk); #1;
      if_ch.W = src_beat(8'h70, 2, 4);
      mac_ch.WReady = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_mac_wvalid", 64'(mac_ch.WValid), 1);
         check("bp_mac_w", 64'(mac_ch.W), 64'(src_beat(8'h70, 2, 4)));
         check("bp_cnt", 64'(dut.r_cnt), 3);
         check("bp_if_wready", 64'(if_ch.WReady), 0);
      end
      @(posedge clk); #1;
      mac_ch.WReady = 1;
      @(posedge clk); #1;
      if_ch.W = src_beat(8'h70, 3, 4);
      mac_ch.WReady = 0;
      #2 resetn = 1'b0;
      #1;
      check("ar_mac_wvalid", 64'(mac_ch.WValid), 0);
      check("ar_mac_w", 64'(mac_ch.W), 0);
      check("ar_mac_valid", 64'(mac_ch.Valid), 0);
      check("ar_mac_req", 64'(mac_ch.Req), 0);
      check("ar_grant", 64'(grant), 0);
      check("ar_if_wready", 64'(if_ch.WReady), 0);
      @(posedge clk); #1;
      if_ch.WValid = 0;
      mac_ch.WReady = 1;
      resetn = 1'b1;
      @(negedge clk);
      check("rel_grant", 64'(grant), 0);
      check("rel_mac_valid", 64'(mac_ch.Valid), 0);
      check("rel_mac_wvalid", 64'(mac_ch.WValid), 0);

      repeat (3) @(posedge clk);
      check("sb_req_drained", 64'(req_q.size()), 0);
      check("sb_beat_drained", 64'(beat_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mai_wr_arbiter.md
# mai_wr_arbiter

QoS-aware write-channel arbiter for the memory access interconnector. It shares a single write-request/write-data port toward the memory access controller (MAC) between the instruction-fetch (IF) and data-memory (DM) requesters. Arbitration uses QoS plus a per-requester age counter. The grant is held for the whole burst, address phase through the last data beat, so data beats of different requesters never interleave.

## Interface
- RW, 45, request bus width = {Addr[31:0], Tag[3:0], Id[2:0], Len[1:0], QoS[3:0]}; QoS in bits [3:0], Len in bits [5:4]
- WW, 37, write-beat bus width = {EoD, Mask[3:0], Data[31:0]}; EoD in bit [36]
- clk  input  1  clock
- resetn  input  1  reset, asynchronous, active-low
- iIF_Valid  input  1  IF write request valid
- iIF_Req  input  RW  IF request fields
- oIF_Ready  output  1  IF request accepted (combinational)
- iIF_WValid  input  1  IF write beat valid
- iIF_W  input  WW  IF write beat
- oIF_WReady  output  1  IF write beat accepted
- iDM_Valid, iDM_Req, oDM_Ready, iDM_WValid, iDM_W, oDM_WReady: same as the IF ports, for DM
- oMAC_Valid  output  1  request valid toward MAC
- oMAC_Req  output  RW  registered granted request
- iMAC_Ready  input  1  MAC accepts request
- oMAC_WValid  output  1  write beat valid toward MAC
- oMAC_W  output  WW  write beat toward MAC
- iMAC_WReady  input  1  MAC accepts beat
- oGrant  output  2  {DM,IF} one-hot current owner; 00 when idle
- oProtoErr  output  1  one-cycle pulse on EoD/Len mismatch

## Operation
- States: IDLE, ADDR, DATA.
- **IDLE, priority:** effective priority per valid requester is P = QoS + age. P is 5 bits, zero-extended sum, no overflow.
- **IDLE, winner selection:**
  - A requester with age == 15 wins outright.
  - Otherwise the higher P wins.
  - Ties, including both aged, go to the requester not granted last (lastGrant register).
- **IDLE, handshake:** the winner's oX_Ready = 1 in the same cycle; the loser's is 0.
- **IDLE, on handshake:**
  - Capture Req into oMAC_Req.
  - Load beat counter cnt = Len + 1 (range 1..4).
  - Set oGrant and lastGrant; clear the winner's age.
  - Increment the loser's age (saturating at 15) if the loser was valid.
  - Go to ADDR.
- **ADDR:** oMAC_Valid = 1, oMAC_Req held stable. On iMAC_Ready go to DATA.
- **DATA (pass-through, combinational):**
  - oMAC_WValid = owner WValid, oMAC_W = owner W, owner WReady = iMAC_WReady.
  - The non-owner WReady is 0.
- **DATA, EoD forcing:** oMAC_W EoD bit = source EoD OR (cnt == 1).
- **DATA, per beat:** each handshake (oMAC_WValid & iMAC_WReady) decrements cnt.
- **DATA, burst end:** on a handshake with source EoD = 1 or cnt == 1, go to IDLE and set oGrant = 00.
- **Protocol error:** pulse oProtoErr for 1 cycle on that final handshake if source EoD != (cnt == 1). This covers early EoD and missing EoD.
- Ages do not change outside the IDLE handshake cycle.
- In ADDR and DATA, oIF_Ready and oDM_Ready are 0.

## Timing
- **Reset values:** every output 0, state IDLE, ages 0, cnt 0. lastGrant = DM, so IF wins the first tie.
- **Reset mid-burst:** asynchronous abort to IDLE; all outputs drop immediately. No beat is replayed.
- **Latency:** request handshake in cycle N gives oMAC_Valid = 1 in cycle N+1.
  - First beat can pass in cycle N+2 if iMAC_Ready is high in N+1.
  - Data path adds 0 cycles.
- **Gap:** the minimum gap between bursts is one IDLE cycle after the last beat.
- **Requester rules:** requesters hold Valid/Req stable until Ready. oMAC_Req is stable while oMAC_Valid is high, regardless of iMAC_Ready.
- **Simultaneous events:** a new request arriving during DATA waits; its age is unaffected until the next IDLE decision.

## Test plan
- **Single IF request:** IF QoS = 3, Len = 2, DM idle, MAC always ready.
  - oIF_Ready in cycle 0, oMAC_Valid in cycle 1.
  - 3 beats pass, EoD on the 3rd, oGrant = 01 then 00.
- **QoS contention:** IF QoS = 2 and DM QoS = 9 valid together.
  - DM is granted first, IF age -> 1.
  - After the DM burst, IF is granted and its age clears.
- **Starvation:** DM QoS = 15 requests continuously, IF QoS = 0 valid.
  - IF loses 15 times, age = 15, and wins the 16th arbitration.
- **Tie round-robin:** equal QoS, both valid repeatedly after reset.
  - Grant order IF, DM, IF, DM.
- **Protocol error:** Len = 3 with EoD on beat 2, then a Len = 0 burst without EoD.
  - First case: burst ends after beat 2 and oProtoErr pulses.
  - Second case: oMAC EoD is forced on the single beat and oProtoErr pulses.
- **Mid-burst reset and backpressure:**
  - resetn asserted in DATA after beat 1: all outputs 0 asynchronously, and IDLE on release.
  - iMAC_WReady low for 3 cycles: the beat is held and cnt is unchanged.
